spart_ctrl: RTL and testbench

Bus-side controller for the SPART. It owns the programmable 16x baud tick that drives the receiver and transmitter. It captures received bytes into a holding buffer and sequences single-byte transmissions. It also exposes a 4-address register map to the processor bus.

---
 rtl/spart_pkg.sv | 23 ++
 rtl/spart_baud_gen.sv | 44 ++++
 rtl/spart_ctrl.sv | 170 +++++++++++++++++
 tb/tb_spart_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: register map, TX states, STATUS layout.
`timescale 1ns/1ps
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    localparam int STATUS_RDA = 0;
    localparam int STATUS_TBR = 1;
    localparam int STATUS_OVR = 2;

    localparam int RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable 16x baud tick: down-counter with byte-writable divisor and reload-on-write.
`timescale 1ns/1ps
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV_RST = 16'd325
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wdata,
    output logic [15:0] divisor,
    output logic        baud_en
);

    logic [15:0] cnt;
    logic [15:0] div_next;

    always_comb begin
        div_next = divisor;
        if (wr_lo) div_next[7:0]  = wdata;
        if (wr_hi) div_next[15:8] = wdata;
    end

    // A divisor write restarts the count from the complete new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor <= BAUD_DIV_RST;
            cnt     <= BAUD_DIV_RST;
        end else begin
            divisor <= div_next;
            if (wr_lo || wr_hi)
                cnt <= div_next;
            else if (cnt == 16'd0)
                cnt <= divisor;
            else
                cnt <= cnt - 16'd1;
        end
    end

    assign baud_en = (cnt == 16'd0);

endmodule

// File: rtl/spart_ctrl.sv
// SPART bus-side controller: register map, RX capture buffer and single-byte TX sequencer.
// Define SPART_RX_FIFO_EN for a 4-entry RX FIFO; otherwise a single holding register is used.
`timescale 1ns/1ps
module spart_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV_RST = 16'd325
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rda,
    output logic       tbr,
    output logic       baud_en,
    input  logic       rx_rda,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy
);

    logic        bus_wr, bus_rd;
    logic        data_wr, status_wr, pop;
    logic [15:0] divisor;
    logic        rx_q, push_q;
    logic [7:0]  rx_byte_q;
    logic        rx_empty, rx_full, push_acc;
    logic [7:0]  rx_head;
    logic        ovr;
    logic [7:0]  tx_hold;
    tx_state_t   state, state_next;

    assign bus_wr    = iocs && !iorw;
    assign bus_rd    = iocs && iorw;
    assign data_wr   = bus_wr && (ioaddr == ADDR_DATA);
    assign status_wr = bus_wr && (ioaddr == ADDR_STATUS);
    assign pop       = bus_rd && (ioaddr == ADDR_DATA) && rda;

    spart_baud_gen #(.BAUD_DIV_RST(BAUD_DIV_RST)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_lo   (bus_wr && (ioaddr == ADDR_DIV_LO)),
        .wr_hi   (bus_wr && (ioaddr == ADDR_DIV_HI)),
        .wdata   (wdata),
        .divisor (divisor),
        .baud_en (baud_en)
    );

    // Rising edge of rx_rda is detected against a registered copy; the push lands one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q      <= 1'b0;
            push_q    <= 1'b0;
            rx_byte_q <= 8'h00;
        end else begin
            rx_q      <= rx_rda;
            push_q    <= rx_rda && !rx_q;
            rx_byte_q <= rx_data;
        end
    end

    assign push_acc = push_q && (!rx_full || pop);

`ifdef SPART_RX_FIFO_EN
    logic [7:0] fifo_mem [RX_FIFO_DEPTH];
    logic [2:0] wr_ptr, rd_ptr;

    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_full  = (wr_ptr[2] != rd_ptr[2]) && (wr_ptr[1:0] == rd_ptr[1:0]);
    assign rx_head  = fifo_mem[rd_ptr[1:0]];

    always_ff @(posedge clk) begin
        if (push_acc) fifo_mem[wr_ptr[1:0]] <= rx_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 3'd1;
            if (pop)      rd_ptr <= rd_ptr + 3'd1;
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_valid;

    assign rx_empty = !rx_valid;
    assign rx_full  = rx_valid;
    assign rx_head  = rx_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            if (push_acc) rx_hold <= rx_byte_q;
            rx_valid <= push_acc || (rx_valid && !pop);
        end
    end
`endif

    assign rda = !rx_empty;

    // A fresh overrun outranks a simultaneous STATUS-write clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovr <= 1'b0;
        else if (push_q && rx_full && !pop)
            ovr <= 1'b1;
        else if (status_wr)
            ovr <= 1'b0;
    end

    always_comb begin
        rdata = 8'h00;
        unique case (ioaddr)
            ADDR_DATA:   rdata = rx_empty ? 8'h00 : rx_head;
            ADDR_STATUS: begin
                rdata[STATUS_RDA] = rda;
                rdata[STATUS_TBR] = tbr;
                rdata[STATUS_OVR] = ovr;
            end
            ADDR_DIV_LO: rdata = divisor[7:0];
            ADDR_DIV_HI: rdata = divisor[15:8];
            default:     rdata = 8'h00;
        endcase
    end

    // tbr doubles as "holding register empty"; it only rises again once LOAD hands the byte over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbr     <= 1'b1;
            tx_hold <= 8'h00;
        end else if (state == TX_LOAD) begin
            tbr <= 1'b1;
        end else if (data_wr && tbr) begin
            tbr     <= 1'b0;
            tx_hold <= wdata;
        end
    end

    assign tx_data = tx_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        unique case (state)
            TX_IDLE:      if (!tbr && !tx_busy) state_next = TX_LOAD;
            TX_LOAD: begin
                tx_start   = 1'b1;
                state_next = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: if (tx_busy) state_next = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) state_next = TX_IDLE;
            default:      state_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spart_ctrl.sv
// Self-checking bench for spart_ctrl with a queue-based RX/TX reference model and a transmitter stub.
`timescale 1ns/1ps
module tb_spart_ctrl;
    import spart_pkg::*;

`ifdef SPART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] wdata, rdata;
    logic       rda, tbr, baud_en;
    logic       rx_rda;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int baud_q[$];
    logic [7:0] tx_log[$];
    int start_cnt = 0;
    int busy_cnt = 0;

    logic [7:0] rx_model[$];
    logic       ovr_model = 1'b0;
    logic [7:0] exp_tx[$];

    spart_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rda      (rda),
        .tbr      (tbr),
        .baud_en  (baud_en),
        .rx_rda   (rx_rda),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && baud_en === 1'b1) baud_q.push_back(cyc);
    end

    // Transmitter stub: latches tx_data on tx_start and stays busy for 10 clocks.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                tx_busy  = 1'b0;
                busy_cnt = 0;
            end else begin
                if (tx_start === 1'b1) begin
                    start_cnt++;
                    tx_log.push_back(tx_data);
                end
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) tx_busy = 1'b0;
                end else if (tx_start === 1'b1) begin
                    tx_busy  = 1'b1;
                    busy_cnt = 10;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        iocs   = cs;
        iorw   = rw;
        ioaddr = a;
        wdata  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
        tick();
        applyStimulus(1'b0, 1'b0, ADDR_DATA, 8'h00);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
        applyStimulus(1'b1, 1'b1, a, 8'h00);
        #1;
        v = rdata;
        tick();
        applyStimulus(1'b0, 1'b0, ADDR_DATA, 8'h00);
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] expv);
        logic [7:0] v;
        bus_read(a, v);
        checkOutput(tag, {24'h0, v}, {24'h0, expv});
    endtask

    function automatic logic [7:0] exp_status(input logic tbr_e);
        return {5'b00000, ovr_model, tbr_e, (rx_model.size() != 0)};
    endfunction

    // Raise rx_rda for a few clocks with one byte; the model applies the buffer-full rule.
    task automatic rx_send(input logic [7:0] b);
        rx_data = b;
        rx_rda  = 1'b1;
        tick(3);
        rx_rda  = 1'b0;
        tick(2);
        if (rx_model.size() < DEPTH) rx_model.push_back(b);
        else                         ovr_model = 1'b1;
    endtask

    initial begin
        int base, n, wr_cyc, starts0, logsz;
        logic [7:0] b, v, div_lo, t, u;

        rst_n   = 1'b0;
        rx_rda  = 1'b0;
        rx_data = 8'h00;
        applyStimulus(1'b0, 1'b0, ADDR_DATA, 8'h00);
        tick(3);
        checkOutput("reset_rdata",    {24'h0, rdata}, 32'h00);
        checkOutput("reset_rda",      {31'h0, rda}, 32'h0);
        checkOutput("reset_tbr",      {31'h0, tbr}, 32'h1);
        checkOutput("reset_baud_en",  {31'h0, baud_en}, 32'h0);
        checkOutput("reset_tx_start", {31'h0, tx_start}, 32'h0);
        checkOutput("reset_tx_data",  {24'h0, tx_data}, 32'h00);
        rst_n = 1'b1;
        tick();
        read_check("status_after_reset", ADDR_STATUS, 8'h02);

        base = baud_q.size();
        tick(1000);
        n = baud_q.size() - base;
        checkOutput("baud_default_count", {31'h0, n >= 3}, 32'h1);
        for (int i = 0; i < 2 && base + i + 1 < baud_q.size(); i++)
            checkOutput("baud_default_gap", baud_q[base+i+1] - baud_q[base+i], 326);

        div_lo = 8'($urandom_range(2, 9));
        bus_write(ADDR_DIV_LO, div_lo);
        bus_write(ADDR_DIV_HI, 8'h00);
        wr_cyc = cyc;
        base   = baud_q.size();
        tick(40);
        n = baud_q.size() - base;
        checkOutput("baud_prog_count", {31'h0, n >= 4}, 32'h1);
        if (n >= 1)
            checkOutput("baud_prog_start", {31'h0, (baud_q[base] - wr_cyc) <= int'(div_lo) + 1}, 32'h1);
        for (int i = 0; i < 3 && base + i + 1 < baud_q.size(); i++)
            checkOutput("baud_prog_gap", baud_q[base+i+1] - baud_q[base+i], int'(div_lo) + 1);
        read_check("div_lo_readback", ADDR_DIV_LO, div_lo);
        read_check("div_hi_readback", ADDR_DIV_HI, 8'h00);

        bus_write(ADDR_DIV_LO, 8'h00);
        base = baud_q.size();
        tick(10);
        checkOutput("baud_div0_every_cycle", baud_q.size() - base, 10);
        bus_write(ADDR_DIV_LO, 8'h03);

        b       = 8'($urandom);
        rx_data = b;
        rx_rda  = 1'b1;
        tick();
        checkOutput("rx_rda_n1", {31'h0, rda}, 32'h0);
        tick();
        checkOutput("rx_rda_n2", {31'h0, rda}, 32'h1);
        tick(18);
        rx_rda = 1'b0;
        tick(2);
        rx_model.push_back(b);
        read_check("rx_single_status", ADDR_STATUS, exp_status(1'b1));
        read_check("rx_single_data", ADDR_DATA, rx_model.pop_front());
        read_check("rx_single_status_after", ADDR_STATUS, exp_status(1'b1));
        read_check("rx_empty_read", ADDR_DATA, 8'h00);

        for (int i = 0; i < DEPTH + 1; i++) rx_send(8'($urandom));
        read_check("ovr_status_set", ADDR_STATUS, exp_status(1'b1));
        for (int i = 0; i < DEPTH; i++) read_check("ovr_data_kept", ADDR_DATA, rx_model.pop_front());
        read_check("ovr_status_drained", ADDR_STATUS, exp_status(1'b1));
        bus_write(ADDR_STATUS, 8'($urandom));
        ovr_model = 1'b0;
        read_check("ovr_status_cleared", ADDR_STATUS, exp_status(1'b1));

        for (int i = 0; i < DEPTH; i++) rx_send(8'($urandom));
        b       = 8'($urandom);
        rx_data = b;
        rx_rda  = 1'b1;
        tick();
        bus_read(ADDR_DATA, v);
        checkOutput("pushpop_head", {24'h0, v}, {24'h0, rx_model.pop_front()});
        rx_model.push_back(b);
        rx_rda = 1'b0;
        tick(2);
        read_check("pushpop_status", ADDR_STATUS, exp_status(1'b1));
        for (int i = 0; i < DEPTH; i++) read_check("pushpop_drain", ADDR_DATA, rx_model.pop_front());
        read_check("pushpop_empty_status", ADDR_STATUS, exp_status(1'b1));

        t       = 8'($urandom);
        u       = ~t;
        starts0 = start_cnt;
        logsz   = tx_log.size();
        exp_tx.push_back(t);
        applyStimulus(1'b1, 1'b0, ADDR_DATA, t);
        tick();
        checkOutput("tx_tbr_n1", {31'h0, tbr}, 32'h0);
        checkOutput("tx_start_n1", {31'h0, tx_start}, 32'h0);
        applyStimulus(1'b1, 1'b0, ADDR_DATA, u);
        tick();
        applyStimulus(1'b0, 1'b0, ADDR_DATA, 8'h00);
        checkOutput("tx_start_n2", {31'h0, tx_start}, 32'h1);
        checkOutput("tx_data_n2", {24'h0, tx_data}, {24'h0, t});
        tick();
        checkOutput("tx_tbr_n3", {31'h0, tbr}, 32'h1);
        checkOutput("tx_start_n3", {31'h0, tx_start}, 32'h0);
        tick(20);
        t = 8'($urandom);
        exp_tx.push_back(t);
        bus_write(ADDR_DATA, t);
        tick(20);
        checkOutput("tx_start_count", start_cnt - starts0, exp_tx.size());
        for (int i = 0; i < exp_tx.size() && logsz + i < tx_log.size(); i++)
            checkOutput("tx_byte", {24'h0, tx_log[logsz+i]}, {24'h0, exp_tx[i]});

        rx_send(8'($urandom));
        bus_write(ADDR_DATA, 8'($urandom));
        tick(4);
        checkOutput("rst_pre_busy", {31'h0, tx_busy}, 32'h1);
        bus_write(ADDR_DATA, 8'($urandom));
        checkOutput("rst_pre_tbr", {31'h0, tbr}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_tbr", {31'h0, tbr}, 32'h1);
        checkOutput("rst_async_rda", {31'h0, rda}, 32'h0);
        checkOutput("rst_async_tx_data", {24'h0, tx_data}, 32'h00);
        rx_model.delete();
        ovr_model = 1'b0;
        tick(2);
        rst_n   = 1'b1;
        starts0 = start_cnt;
        tick(30);
        checkOutput("rst_no_tx_start", start_cnt - starts0, 0);
        checkOutput("rst_post_tbr", {31'h0, tbr}, 32'h1);
        checkOutput("rst_post_rda", {31'h0, rda}, 32'h0);
        read_check("rst_post_status", ADDR_STATUS, exp_status(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
